// File: rtl/tc_stim_misr_if.sv
// Operand/result bus between the stimulus harness and the tensorcore.
// The harness is the master: it drives the operand tiles and consumes results.
interface tc_stim_misr_if #(
    parameter int M = 4,
    parameter int K = 8,
    parameter int N = 4
);
    logic                in_valid;
    logic                e5m2mode;
    logic [M*K*8-1:0]    a;
    logic [K*N*8-1:0]    b;
    logic [M*N*16-1:0]   c;
    logic                out_valid;
    logic [M*N*16-1:0]   d;

    modport master (
        output in_valid, e5m2mode, a, b, c,
        input  out_valid, d
    );

    modport slave (
        input  in_valid, e5m2mode, a, b, c,
        output out_valid, d
    );
endinterface

// File: rtl/tc_stim_misr.sv
// LFSR-driven operand generator and MISR result compactor for the tensorcore.
// Issues NUM_TXN back-to-back transactions, folds every returned D tile into a
// 32-bit signature and reports done/pass/timeout once the results are in.
module tc_stim_misr #(
    parameter int          M           = 4,
    parameter int          K           = 8,
    parameter int          N           = 4,
    parameter int          NUM_TXN     = 1024,
    parameter logic [31:0] LFSR_SEED   = 32'hACE12024,
    parameter logic [31:0] GOLDEN_SIG  = 32'h00000000,
    parameter int          MODE_ALT    = 1,
    parameter int          MAX_LATENCY = 64
) (
    input  logic           clk_600m,
    input  logic           rst,
    input  logic           start,
    tc_stim_misr_if.master bus,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic           timeout,
    output logic [31:0]    signature,
    output logic [7:0]     led
);
    localparam int          MK   = M * K;
    localparam int          KN   = K * N;
    localparam int          MN   = M * N;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam int          TW   = $clog2(NUM_TXN + 1);
    localparam int          LW   = $clog2(MAX_LATENCY + 1);
    localparam logic [TW-1:0] TXN_TOTAL = TW'(NUM_TXN);
    localparam logic [LW-1:0] LAT_LAST  = LW'(MAX_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Same Galois feedback is shared by the operand LFSR and the MISR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     misr_q, misr_d;
    logic [TW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [TW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [LW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            in_valid_q, in_valid_d;
    logic            e5m2_q, e5m2_d;
    logic [MK*8-1:0] a_q, a_d;
    logic [KN*8-1:0] b_q, b_d;
    logic [MN*16-1:0] c_q, c_d;
    logic            pass_q, pass_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            restart;
    logic            accept;
    logic            issue;
    logic [TW-1:0]   issue_n;
    logic [31:0]     gen_src;
    logic [46:0]     rot_win;
    logic [MK*8-1:0] gen_a;
    logic [KN*8-1:0] gen_b;
    logic [MN*16-1:0] gen_c;
    logic [31:0]     fold;
    logic [31:0]     misr_step;

    // A start from IDLE/DONE issues transaction 0 in the same cycle, so the
    // generator must see the seed rather than whatever the LFSR holds.
    assign restart = start && (state_q == S_IDLE || state_q == S_DONE);
    assign gen_src = restart ? LFSR_SEED : lfsr_q;

    // rot_win[(31-r) +: w] is the low w bits of gen_src rotated left by r.
    assign rot_win = {gen_src[15:0], gen_src[31:1]};

    for (genvar e = 0; e < MK; e++) begin : g_a
        assign gen_a[e*8 +: 8] = rot_win[(31 - (e * 5) % 32) +: 8];
    end
    for (genvar e = 0; e < KN; e++) begin : g_b
        assign gen_b[e*8 +: 8] = rot_win[(31 - ((MK + e) * 5) % 32) +: 8];
    end
    for (genvar e = 0; e < MN; e++) begin : g_c
        assign gen_c[e*16 +: 16] = rot_win[(31 - ((MK + KN + e) * 5) % 32) +: 16];
    end

    // Fold the D tile: even-index elements into the low half, odd into the high.
    always_comb begin
        fold = '0;
        for (int i = 0; i < MN; i++) begin
            if (i % 2 == 0) fold[15:0]  = fold[15:0]  ^ bus.d[i*16 +: 16];
            else            fold[31:16] = fold[31:16] ^ bus.d[i*16 +: 16];
        end
    end

    assign misr_step = lfsr_next(misr_q) ^ fold;

    // Next-state, issue and capture logic.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        idle_cnt_d = idle_cnt_q;
        in_valid_d = 1'b0;
        e5m2_d     = e5m2_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        issue      = 1'b0;
        issue_n    = tx_cnt_q;

        // Results beyond NUM_TXN or outside a run are dropped silently.
        accept = (state_q == S_RUN || state_q == S_DRAIN) && bus.out_valid &&
                 (rx_cnt_q < TXN_TOTAL);
        if (accept) begin
            misr_d   = misr_step;
            rx_cnt_d = rx_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    misr_d     = '0;
                    rx_cnt_d   = '0;
                    idle_cnt_d = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    issue      = 1'b1;
                    issue_n    = '0;
                end
            end
            S_RUN: begin
                if (tx_cnt_q < TXN_TOTAL) begin
                    issue = 1'b1;
                end else begin
                    state_d    = S_DRAIN;
                    idle_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                // Completion is checked on the post-capture count so a final
                // result arriving on the timeout cycle still wins.
                if (rx_cnt_d == TXN_TOTAL) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    pass_d    = (misr_d == GOLDEN_SIG);
                end else if (!accept && idle_cnt_q == LAT_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    idle_cnt_d = accept ? '0 : idle_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            in_valid_d = 1'b1;
            e5m2_d     = (MODE_ALT != 0) && issue_n[0];
            a_d        = gen_a;
            b_d        = gen_b;
            c_d        = gen_c;
            lfsr_d     = lfsr_next(gen_src);
            tx_cnt_d   = issue_n + 1'b1;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; synchronous reset aborts any run.
    always_ff @(posedge clk_600m) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            misr_q     <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            idle_cnt_q <= '0;
            in_valid_q <= 1'b0;
            e5m2_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            in_valid_q <= in_valid_d;
            e5m2_q     <= e5m2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_valid = in_valid_q;
    assign bus.e5m2mode = e5m2_q;
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.c        = c_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign signature    = misr_q;
    assign led          = {done_q, pass_q, timeout_q, busy_q, misr_q[3:0]};
endmodule

// File: tb/tb_tc_stim_misr.sv
// Bench for tc_stim_misr: two instances (matching and mismatching golden
// signature) driven by a fixed-latency-3 tensorcore stand-in returning d = c.
module tb_tc_stim_misr;
    localparam int          M    = 4;
    localparam int          K    = 8;
    localparam int          N    = 4;
    localparam int          NT   = 4;
    localparam int          ML   = 8;
    localparam int          MK   = M * K;
    localparam int          KN   = K * N;
    localparam int          MN   = M * N;
    localparam logic [31:0] SEED = 32'hACE12024;
    localparam logic [31:0] POLY = 32'h80200003;

    function automatic logic [31:0] step32(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] s, input int r);
        logic [63:0] w;
        w = {s, s} << r;
        return w[63:32];
    endfunction

    function automatic logic [31:0] state_n(input int n);
        logic [31:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = step32(s);
        return s;
    endfunction

    function automatic logic [31:0] elem(input logic [31:0] s, input int e);
        return rotl(s, (e * 5) % 32);
    endfunction

    // Signature after folding the C tiles (echoed as D) of transactions 0..num-1.
    function automatic logic [31:0] ref_sig(input int num);
        logic [31:0] sig, s, f, x;
        sig = 32'h0;
        s   = SEED;
        for (int n = 0; n < num; n++) begin
            f = 32'h0;
            for (int i = 0; i < MN; i++) begin
                x = elem(s, MK + KN + i);
                if (i % 2 == 0) f[15:0]  = f[15:0]  ^ x[15:0];
                else            f[31:16] = f[31:16] ^ x[15:0];
            end
            sig = step32(sig) ^ f;
            s   = step32(s);
        end
        return sig;
    endfunction

    localparam logic [31:0] GOLD = ref_sig(NT);

    logic clk_600m = 1'b0;
    logic rst, start;
    logic busy0, done0, pass0, tmo0, busy1, done1, pass1, tmo1;
    logic [31:0] sig0, sig1;
    logic [7:0]  led0, led1;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_600m = ~clk_600m;

    tc_stim_misr_if #(.M(M), .K(K), .N(N)) bif0 ();
    tc_stim_misr_if #(.M(M), .K(K), .N(N)) bif1 ();

    tc_stim_misr #(.M(M), .K(K), .N(N), .NUM_TXN(NT), .LFSR_SEED(SEED),
                   .GOLDEN_SIG(GOLD), .MODE_ALT(1), .MAX_LATENCY(ML)) u0 (
        .clk_600m(clk_600m), .rst(rst), .start(start), .bus(bif0.master),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(tmo0),
        .signature(sig0), .led(led0));

    tc_stim_misr #(.M(M), .K(K), .N(N), .NUM_TXN(NT), .LFSR_SEED(SEED),
                   .GOLDEN_SIG(GOLD ^ 32'h1), .MODE_ALT(1), .MAX_LATENCY(ML)) u1 (
        .clk_600m(clk_600m), .rst(rst), .start(start), .bus(bif1.master),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(tmo1),
        .signature(sig1), .led(led1));

    // Tensorcore stand-in: 3-cycle latency, d = c; u0 can drop its last result.
    logic [2:0]        vq0 = '0, vq1 = '0;
    logic [MN*16-1:0]  cq0 [3];
    logic [MN*16-1:0]  cq1 [3];
    int                icnt0 = 0;
    logic              drop0 = 1'b0;
    logic              xov = 1'b0;
    logic [MN*16-1:0]  xd = '0;

    always @(posedge clk_600m) begin
        if (start) icnt0 <= 0;
        else if (bif0.in_valid) icnt0 <= icnt0 + 1;
        vq0    <= {vq0[1:0], bif0.in_valid && !(drop0 && icnt0 == NT - 1)};
        vq1    <= {vq1[1:0], bif1.in_valid};
        cq0[0] <= bif0.c; cq0[1] <= cq0[0]; cq0[2] <= cq0[1];
        cq1[0] <= bif1.c; cq1[1] <= cq1[0]; cq1[2] <= cq1[1];
    end

    assign bif0.out_valid = vq0[2] | xov;
    assign bif0.d         = xov ? xd : cq0[2];
    assign bif1.out_valid = vq1[2] | xov;
    assign bif1.d         = xov ? xd : cq1[2];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_tiles(input int n, input string tag);
        logic [31:0]      s, x;
        logic [MK*8-1:0]  ea;
        logic [KN*8-1:0]  eb;
        logic [MN*16-1:0] ec;
        s = state_n(n);
        for (int e = 0; e < MK; e++) begin x = elem(s, e);           ea[e*8 +: 8]   = x[7:0];  end
        for (int e = 0; e < KN; e++) begin x = elem(s, MK + e);      eb[e*8 +: 8]   = x[7:0];  end
        for (int e = 0; e < MN; e++) begin x = elem(s, MK + KN + e); ec[e*16 +: 16] = x[15:0]; end
        chk($sformatf("%s_a%0d", tag, n), bif0.a, ea);
        chk($sformatf("%s_b%0d", tag, n), bif0.b, eb);
        chk($sformatf("%s_c%0d", tag, n), bif0.c, ec);
    endtask

    // Called on the negedge where transaction 0 is visible; returns on the
    // negedge after the last issue.
    task automatic issue_seq(input string tag);
        for (int n = 0; n < NT; n++) begin
            chk($sformatf("%s_iv%0d", tag, n), bif0.in_valid, 1'b1);
            chk($sformatf("%s_mode%0d", tag, n), bif0.e5m2mode, n % 2);
            chk($sformatf("%s_busy%0d", tag, n), busy0, 1'b1);
            check_tiles(n, tag);
            if (n == 0) chk($sformatf("%s_a_lo0", tag), bif0.a[7:0], 8'h24);
            if (n == 1) chk($sformatf("%s_a_lo1", tag), bif0.a[7:0], 8'h4B);
            @(negedge clk_600m);
        end
        chk($sformatf("%s_iv_end", tag), bif0.in_valid, 1'b0);
        chk($sformatf("%s_busy_drain", tag), busy0, 1'b1);
        check_tiles(NT - 1, {tag, "_hold"});
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk_600m);
        rst = 1'b0;

        // Idle after reset, no start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_600m);
            chk("rst_iv", bif0.in_valid, 1'b0);
            chk("rst_flags", {busy0, done0, pass0, tmo0}, 4'b0);
            chk("rst_led", led0, 8'h0);
            chk("rst_sig", sig0, 32'h0);
            chk("rst_abc", {bif0.a, bif0.b, bif0.c}, '0);
        end

        // Run A: full run, both verdicts.
        start = 1'b1;
        @(negedge clk_600m);
        start = 1'b0;
        issue_seq("runA");
        repeat (2) @(negedge clk_600m);
        chk("runA_done_early", done0, 1'b0);
        @(negedge clk_600m);
        chk("runA_done0", {done0, pass0, tmo0, busy0}, 4'b1100);
        chk("runA_sig0", sig0, GOLD);
        chk("runA_led0", led0, {4'b1100, GOLD[3:0]});
        chk("runA_done1", {done1, pass1, tmo1}, 3'b100);
        chk("runA_sig1", sig1, GOLD);

        // Stray results in DONE are ignored.
        xd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        xov = 1'b1;
        @(negedge clk_600m);
        xov = 1'b0;
        @(negedge clk_600m);
        chk("done_xov_sig0", sig0, GOLD);
        chk("done_xov_sig1", sig1, GOLD);
        chk("done_xov_st", {done0, pass0}, 2'b11);

        // Run B: u0 loses its last result and must time out.
        repeat ($urandom_range(1, 4)) @(negedge clk_600m);
        drop0 = 1'b1;
        start = 1'b1;
        @(negedge clk_600m);
        start = 1'b0;
        chk("runB_clear", {done0, pass0, sig0}, 34'h0);
        check_tiles(0, "runB");
        repeat (13) @(negedge clk_600m);
        chk("runB_done_early", done0, 1'b0);
        @(negedge clk_600m);
        chk("runB_tmo", {done0, pass0, tmo0, busy0}, 4'b1010);
        chk("runB_sig", sig0, ref_sig(NT - 1));
        chk("runB_led", led0[7:4], 4'b1010);
        chk("runB_u1", {done1, pass1, tmo1}, 3'b100);
        drop0 = 1'b0;

        // Run C: reset while transaction 1 is on the bus, then restart.
        repeat ($urandom_range(1, 4)) @(negedge clk_600m);
        start = 1'b1;
        @(negedge clk_600m);
        start = 1'b0;
        chk("runC_tmo_clr", tmo0, 1'b0);
        @(negedge clk_600m);
        rst = 1'b1;
        @(negedge clk_600m);
        rst = 1'b0;
        chk("abort_iv", bif0.in_valid, 1'b0);
        chk("abort_flags", {busy0, done0, pass0, tmo0}, 4'b0);
        chk("abort_sig", sig0, 32'h0);
        chk("abort_a", bif0.a, '0);
        xd  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        xov = 1'b1;
        @(negedge clk_600m);
        xov = 1'b0;
        repeat (5) @(negedge clk_600m);
        chk("idle_xov_sig", sig0, 32'h0);
        chk("idle_xov_busy", busy0, 1'b0);
        start = 1'b1;
        @(negedge clk_600m);
        start = 1'b0;
        issue_seq("runC");
        repeat (3) @(negedge clk_600m);
        chk("runC_done", {done0, pass0, tmo0}, 3'b110);
        chk("runC_sig", sig0, GOLD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
